// File: rtl/mem_stage.sv
// MEM pipeline stage: byte/half/word loads and stores on an internal word-addressed RAM, registered into MEM/WB.
// Optional MEM_STAGE_DEBUG_PORT_EN adds a registered debug read port (i_dbg_addr / o_dbg_data).
module mem_stage #(
  parameter int NB      = 32,
  parameter int NB_ADDR = 8,
  parameter int NB_REG  = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_unsigned,
  input  logic              i_mem_to_reg,
  input  logic              i_reg_write,
  input  logic [NB_REG-1:0] i_rd,
  input  logic [NB-1:0]     i_alu_result,
  input  logic [NB-1:0]     i_data_b_to_write,
`ifdef MEM_STAGE_DEBUG_PORT_EN
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB-1:0]      o_dbg_data,
`endif
  output logic [NB-1:0]     o_mem_fwd_data,
  output logic [NB-1:0]     o_wb_data,
  output logic [NB_REG-1:0] o_rd,
  output logic              o_reg_write,
  output logic              o_valid,
  output logic              o_misaligned
);

  localparam int NLANES = NB / 8;

  logic [NB-1:0]      mem [2**NB_ADDR];
  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic [NB-1:0]      rd_word;
  logic [7:0]         byte_val;
  logic [15:0]        half_val;
  logic [NB-1:0]      load_val;
  logic [NB-1:0]      wdata;
  logic [NLANES-1:0]  be;
  logic               misaligned;
  logic               store_en;

  assign word_idx       = i_alu_result[NB_ADDR+1:2];
  assign lane           = i_alu_result[1:0];
  assign o_mem_fwd_data = i_alu_result;

  assign misaligned = i_valid & (i_mem_read | i_mem_write) &
                      (((i_mem_size == 2'b01) & lane[0]) | (i_mem_size[1] & (lane != 2'b00)));
  assign store_en   = i_valid & i_mem_write & ~misaligned & ~i_stall & ~i_flush & ~i_reset;

  // Per-lane byte enable and write data: narrow stores are replicated into the addressed lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      localparam logic [1:0] LANE_ID = 2'(gi % 4);
      assign be[gi] = (i_mem_size == 2'b00) ? (lane == LANE_ID) :
                      (i_mem_size == 2'b01) ? (lane[1] == LANE_ID[1]) : 1'b1;
      assign wdata[gi*8 +: 8] = (i_mem_size == 2'b00) ? i_data_b_to_write[7:0] :
                                (i_mem_size == 2'b01) ? i_data_b_to_write[(gi%2)*8 +: 8] :
                                                        i_data_b_to_write[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NLANES; i++) begin
      if (store_en && be[i]) mem[word_idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // Load path reads the word asynchronously; the MEM/WB register supplies the one-cycle latency.
  assign rd_word  = mem[word_idx];
  assign byte_val = rd_word[{lane, 3'b000} +: 8];
  assign half_val = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_val = rd_word;
    case (i_mem_size)
      2'b00:   load_val = i_mem_unsigned ? {{(NB-8){1'b0}}, byte_val}
                                         : {{(NB-8){byte_val[7]}}, byte_val};
      2'b01:   load_val = i_mem_unsigned ? {{(NB-16){1'b0}}, half_val}
                                         : {{(NB-16){half_val[15]}}, half_val};
      default: load_val = rd_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_data    <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (i_flush) begin
      o_reg_write  <= 1'b0;
      o_valid      <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (!i_stall) begin
      o_wb_data    <= i_mem_to_reg ? load_val : i_alu_result;
      o_rd         <= i_rd;
      o_reg_write  <= i_valid & i_reg_write & ~misaligned;
      o_valid      <= i_valid;
      o_misaligned <= misaligned;
    end
  end

`ifdef MEM_STAGE_DEBUG_PORT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) o_dbg_data <= '0;
    else         o_dbg_data <= mem[i_dbg_addr];
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: stores/loads of every size, misalignment, stall/flush, reset.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, valid, stall, flush, mem_read, mem_write, mem_unsigned, mem_to_reg, reg_write;
  logic [1:0]  mem_size;
  logic [4:0]  rd;
  logic [31:0] alu_result, data_b;
  logic [31:0] mem_fwd_data, wb_data;
  logic [4:0]  rd_out;
  logic        reg_write_out, valid_out, misaligned_out;
`ifdef MEM_STAGE_DEBUG_PORT_EN
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_data;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_mem_read(mem_read), .i_mem_write(mem_write), .i_mem_size(mem_size),
    .i_mem_unsigned(mem_unsigned), .i_mem_to_reg(mem_to_reg), .i_reg_write(reg_write),
    .i_rd(rd), .i_alu_result(alu_result), .i_data_b_to_write(data_b),
`ifdef MEM_STAGE_DEBUG_PORT_EN
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data),
`endif
    .o_mem_fwd_data(mem_fwd_data), .o_wb_data(wb_data), .o_rd(rd_out),
    .o_reg_write(reg_write_out), .o_valid(valid_out), .o_misaligned(misaligned_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one EX/MEM entry, advance one edge, sample 1 time unit later.
  task automatic step(input logic v, input logic rdn, input logic wrn, input logic [1:0] sz,
                      input logic uns, input logic m2r, input logic rw, input logic [4:0] rdi,
                      input logic [31:0] alu, input logic [31:0] dat);
    valid = v; mem_read = rdn; mem_write = wrn; mem_size = sz; mem_unsigned = uns;
    mem_to_reg = m2r; reg_write = rw; rd = rdi; alu_result = alu; data_b = dat;
    @(posedge clk);
    #1;
    $display("step v=%0b r=%0b w=%0b sz=%0d addr=%h data=%h stall=%0b flush=%0b rst=%0b -> wb=%h rd=%0d rw=%0b val=%0b mis=%0b",
             v, rdn, wrn, sz, alu, dat, stall, flush, reset, wb_data, rd_out, reg_write_out,
             valid_out, misaligned_out);
  endtask

  task automatic sw(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] dat);
    step(1'b1, 1'b0, 1'b1, sz, 1'b0, 1'b0, 1'b0, 5'd0, addr, dat);
  endtask

  task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] addr, input logic [4:0] rdi);
    step(1'b1, 1'b1, 1'b0, sz, uns, 1'b1, 1'b1, rdi, addr, 32'h0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    mem_to_reg = 1'b1; reg_write = 1'b1; rd = 5'd4; alu_result = 32'h55; data_b = 32'h0;
`ifdef MEM_STAGE_DEBUG_PORT_EN
    dbg_addr = 8'd4;
`endif
    @(posedge clk); @(posedge clk); #1;
    chk("reset_wb_data", wb_data, 32'h0);
    chk("reset_rd", {27'h0, rd_out}, 32'h0);
    chk("reset_reg_write", {31'h0, reg_write_out}, 32'h0);
    chk("reset_valid", {31'h0, valid_out}, 32'h0);
    chk("reset_misaligned", {31'h0, misaligned_out}, 32'h0);
    chk("fwd_comb", mem_fwd_data, 32'h55);
    reset = 1'b0;

    sw(2'b10, 32'h10, 32'hDEADBEEF);
    chk("sw_valid", {31'h0, valid_out}, 32'h1);
    chk("sw_reg_write", {31'h0, reg_write_out}, 32'h0);
    ld(2'b10, 1'b0, 32'h10, 5'd3);
    chk("lw_deadbeef", wb_data, 32'hDEADBEEF);
    chk("lw_reg_write", {31'h0, reg_write_out}, 32'h1);
    chk("lw_rd", {27'h0, rd_out}, 32'h3);

    sw(2'b10, 32'h10, 32'h0);
    sw(2'b00, 32'h13, 32'h000000A5);
    ld(2'b00, 1'b0, 32'h13, 5'd5);
    chk("lb_signed", wb_data, 32'hFFFFFFA5);
    ld(2'b00, 1'b1, 32'h13, 5'd5);
    chk("lbu", wb_data, 32'h000000A5);
    ld(2'b10, 1'b0, 32'h10, 5'd5);
    chk("lw_after_sb", wb_data, 32'hA5000000);

    sw(2'b01, 32'h22, 32'h00008001);
    ld(2'b01, 1'b0, 32'h22, 5'd6);
    chk("lh_signed", wb_data, 32'hFFFF8001);
    ld(2'b01, 1'b1, 32'h22, 5'd6);
    chk("lhu", wb_data, 32'h00008001);
    ld(2'b01, 1'b0, 32'h21, 5'd6);
    chk("lh_mis_flag", {31'h0, misaligned_out}, 32'h1);
    chk("lh_mis_reg_write", {31'h0, reg_write_out}, 32'h0);
    chk("lh_mis_valid", {31'h0, valid_out}, 32'h1);

    sw(2'b10, 32'h0C, 32'hCAFEF00D);
    chk("aligned_sw_no_mis", {31'h0, misaligned_out}, 32'h0);
    sw(2'b10, 32'h0E, 32'h11111111);
    chk("sw_mis_flag", {31'h0, misaligned_out}, 32'h1);
    ld(2'b10, 1'b0, 32'h0C, 5'd7);
    chk("sw_mis_suppressed", wb_data, 32'hCAFEF00D);
    chk("mis_pulse_cleared", {31'h0, misaligned_out}, 32'h0);

    alu_result = 32'h00012345; #1;
    chk("fwd_comb_alu", mem_fwd_data, 32'h00012345);
    step(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 5'd9, 32'h00012345, 32'h0);
    chk("alu_wb", wb_data, 32'h00012345);
    chk("alu_rd", {27'h0, rd_out}, 32'h9);

    sw(2'b10, 32'h30, 32'h0);
    stall = 1'b1;
    sw(2'b10, 32'h30, 32'h12345678);
    chk("stall_hold_wb", wb_data, 32'h30);
    chk("stall_hold_valid", {31'h0, valid_out}, 32'h1);
    stall = 1'b0;
    ld(2'b10, 1'b0, 32'h30, 5'd10);
    chk("stall_no_store", wb_data, 32'h0);

    stall = 1'b1; flush = 1'b1;
    sw(2'b10, 32'h30, 32'h00000077);
    chk("flush_valid", {31'h0, valid_out}, 32'h0);
    chk("flush_wb_hold", wb_data, 32'h0);
    chk("flush_rd_hold", {27'h0, rd_out}, 32'hA);
    stall = 1'b0; flush = 1'b0;
    ld(2'b10, 1'b0, 32'h30, 5'd11);
    chk("flush_no_store", wb_data, 32'h0);

    step(1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 1'b1, 5'd12, 32'h31, 32'h0);
    chk("invalid_valid", {31'h0, valid_out}, 32'h0);
    chk("invalid_reg_write", {31'h0, reg_write_out}, 32'h0);
    chk("invalid_no_mis", {31'h0, misaligned_out}, 32'h0);

    step(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 5'd13, 32'h0C, 32'h0BADF00D);
    chk("rw_old_word", wb_data, 32'hCAFEF00D);
    ld(2'b10, 1'b0, 32'h0C, 5'd13);
    chk("rw_store_done", wb_data, 32'h0BADF00D);

    ld(2'b10, 1'b0, 32'h10, 5'd14);
    chk("pre_reset_load", wb_data, 32'hA5000000);
    reset = 1'b1;
    ld(2'b10, 1'b0, 32'h10, 5'd14);
    chk("midreset_wb", wb_data, 32'h0);
    chk("midreset_valid", {31'h0, valid_out}, 32'h0);
    chk("midreset_rd", {27'h0, rd_out}, 32'h0);
    reset = 1'b0;
    ld(2'b10, 1'b0, 32'h10, 5'd14);
    chk("mem_retained", wb_data, 32'hA5000000);
`ifdef MEM_STAGE_DEBUG_PORT_EN
    chk("dbg_read", dbg_data, 32'hA5000000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
